// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : tick-paced push-button debouncer with press/release/long events
// Revision     : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int CNT_WIDTH      = 11
) (
    input  logic clk_100Mhz,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pressed,
    output logic btn_released,
    output logic btn_long
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_DEB_LAST  = CNT_WIDTH'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] C_LONG_LAST = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] C_ONE       = CNT_WIDTH'(1);

    logic                 r_sync_0;
    logic                 r_sync_1;
    logic                 w_btn_sync;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_dcnt;
    logic [CNT_WIDTH-1:0] w_dcnt_nxt;
    logic [CNT_WIDTH-1:0] r_lcnt;
    logic [CNT_WIDTH-1:0] w_lcnt_nxt;
    logic                 r_long_done;
    logic                 w_long_done_nxt;

    logic                 r_level;
    logic                 r_pressed;
    logic                 r_released;
    logic                 r_long;
    logic                 w_level_nxt;
    logic                 w_pressed_nxt;
    logic                 w_released_nxt;
    logic                 w_long_nxt;

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= btn_in;
            r_sync_1 <= r_sync_0;
        end
    end

    assign w_btn_sync = r_sync_1;

    // A level change always takes priority over a coincident tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_dcnt_nxt      = r_dcnt;
        w_lcnt_nxt      = r_lcnt;
        w_long_done_nxt = r_long_done;
        w_pressed_nxt   = 1'b0;
        w_released_nxt  = 1'b0;
        w_long_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_sync) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_btn_sync) begin
                    w_state_nxt = ST_IDLE;
                end else if (tick) begin
                    if (r_dcnt == C_DEB_LAST) begin
                        w_state_nxt     = ST_PRESSED;
                        w_pressed_nxt   = 1'b1;
                        w_lcnt_nxt      = '0;
                        w_long_done_nxt = 1'b0;
                    end else begin
                        w_dcnt_nxt = r_dcnt + C_ONE;
                    end
                end
            end
            ST_PRESSED: begin
                if (!w_btn_sync) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_dcnt_nxt  = '0;
                end else if (tick && !r_long_done) begin
                    if (r_lcnt == C_LONG_LAST) begin
                        w_long_nxt      = 1'b1;
                        w_long_done_nxt = 1'b1;
                    end else begin
                        w_lcnt_nxt = r_lcnt + C_ONE;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                // Bounce back keeps the long-press progress intact.
                if (w_btn_sync) begin
                    w_state_nxt = ST_PRESSED;
                end else if (tick) begin
                    if (r_dcnt == C_DEB_LAST) begin
                        w_state_nxt    = ST_IDLE;
                        w_released_nxt = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + C_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dcnt      <= '0;
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_pressed   <= 1'b0;
            r_released  <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_long_done <= w_long_done_nxt;
            r_level     <= w_level_nxt;
            r_pressed   <= w_pressed_nxt;
            r_released  <= w_released_nxt;
            r_long      <= w_long_nxt;
        end
    end

    assign btn_level    = r_level;
    assign btn_pressed  = r_pressed;
    assign btn_released = r_released;
    assign btn_long     = r_long;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
// tb_btn_debounce : scoreboard bench for btn_debounce (DEBOUNCE=4, LONG=10)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_btn_debounce;

    localparam int DEB      = 4;
    localparam int LONG     = 10;
    localparam int TICK_PER = 10;

    localparam logic [1:0] EV_PRESS = 2'd1;
    localparam logic [1:0] EV_REL   = 2'd2;
    localparam logic [1:0] EV_LONG  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic clk_100Mhz;
    logic rst_n;
    logic tick;
    logic btn_in;
    logic btn_level;
    logic btn_pressed;
    logic btn_released;
    logic btn_long;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   multi = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    btn_debounce #(
        .DEBOUNCE_TICKS (DEB),
        .LONG_TICKS     (LONG),
        .CNT_WIDTH      (11)
    ) u_dut (
        .clk_100Mhz   (clk_100Mhz),
        .rst_n        (rst_n),
        .tick         (tick),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .btn_pressed  (btn_pressed),
        .btn_released (btn_released),
        .btn_long     (btn_long)
    );

    initial begin
        clk_100Mhz = 1'b0;
        forever #5 clk_100Mhz = ~clk_100Mhz;
    end

    // cyc == n between rising edge n and rising edge n+1
    initial forever begin
        @(posedge clk_100Mhz);
        cyc++;
    end

    // tick is sampled high on every rising edge whose number is a multiple of TICK_PER
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk_100Mhz);
            tick = ((cyc + 1) % TICK_PER == 0);
        end
    end

    initial forever begin
        @(negedge clk_100Mhz);
        if (btn_pressed === 1'b1)  obs_q.push_back(mk(EV_PRESS, cyc));
        if (btn_released === 1'b1) obs_q.push_back(mk(EV_REL, cyc));
        if (btn_long === 1'b1)     obs_q.push_back(mk(EV_LONG, cyc));
        if (int'(btn_pressed === 1'b1) + int'(btn_released === 1'b1) + int'(btn_long === 1'b1) > 1)
            multi++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic ev_t mk(input logic [1:0] k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c[31:0];
        return e;
    endfunction

    // Rising edge number of the n-th tick strictly after edge e
    function automatic int nth_tick(input int e, input int n);
        return ((e / TICK_PER) + n) * TICK_PER;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_100Mhz);
    endtask

    // Edge n+1 samples btn_in, n+2 synchronised, n+3 FSM leaves IDLE/PRESSED
    task automatic press(output int e);
        btn_in = 1'b1;
        e = nth_tick(cyc + 3, DEB);
        exp_q.push_back(mk(EV_PRESS, e));
    endtask

    task automatic release_btn(output int r);
        btn_in = 1'b0;
        r = nth_tick(cyc + 3, DEB);
        exp_q.push_back(mk(EV_REL, r));
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        btn_in = 1'b0;
        repeat (3) @(negedge clk_100Mhz);
        total++; if (btn_level !== 1'b0)    begin bad++; $display("FAIL reset_level: got %b want 0", btn_level); end
        total++; if (btn_pressed !== 1'b0)  begin bad++; $display("FAIL reset_pressed: got %b want 0", btn_pressed); end
        total++; if (btn_released !== 1'b0) begin bad++; $display("FAIL reset_released: got %b want 0", btn_released); end
        total++; if (btn_long !== 1'b0)     begin bad++; $display("FAIL reset_long: got %b want 0", btn_long); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk_100Mhz);
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL reset_quiet: got %0d events want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_clean_press;
        int e, r, s;
        ev_t ex, ob;
        s = cyc;
        press(e);
        wait_cyc(e - 1);
        total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL clean_level_early: got %b want 0", btn_level); end
        wait_cyc(e);
        total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL clean_level_on: got %b want 1", btn_level); end
        wait_cyc(s + 100);
        release_btn(r);
        wait_cyc(r - 1);
        total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL clean_level_held: got %b want 1", btn_level); end
        wait_cyc(r);
        total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL clean_level_off: got %b want 0", btn_level); end
        wait_cyc(r + 3);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (obs_q.size() == 0) begin
                bad++; ex = exp_q.pop_front();
                $display("FAIL clean_event: got none want kind=%0d cyc=%0d", ex.kind, ex.cyc);
            end else if (exp_q.size() == 0) begin
                bad++; ob = obs_q.pop_front();
                $display("FAIL clean_event: got kind=%0d cyc=%0d want none", ob.kind, ob.cyc);
            end else begin
                ex = exp_q.pop_front(); ob = obs_q.pop_front();
                if (ob !== ex) begin
                    bad++;
                    $display("FAIL clean_event: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", ob.kind, ob.cyc, ex.kind, ex.cyc);
                end
            end
        end
    endtask

    task automatic test_bounce;
        int hi = 0;
        for (int i = 0; i < 14; i++) begin
            btn_in = ~btn_in;
            repeat (15) begin
                @(negedge clk_100Mhz);
                if (btn_level !== 1'b0) hi++;
            end
        end
        btn_in = 1'b0;
        repeat (60) begin
            @(negedge clk_100Mhz);
            if (btn_level !== 1'b0) hi++;
        end
        total++; if (hi !== 0) begin bad++; $display("FAIL bounce_level: got %0d high cycles want 0", hi); end
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL bounce_events: got %0d events want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_release_bounce;
        int e, r;
        int lo = 0;
        ev_t ex, ob;
        press(e);
        wait_cyc(e);
        while (cyc < e + 35) begin
            if (cyc == e + 5)  btn_in = 1'b0;
            if (cyc == e + 30) btn_in = 1'b1;
            if (btn_level !== 1'b1) lo++;
            @(negedge clk_100Mhz);
        end
        release_btn(r);
        while (cyc < r) begin
            if (btn_level !== 1'b1) lo++;
            @(negedge clk_100Mhz);
        end
        total++; if (lo !== 0) begin bad++; $display("FAIL relb_level_held: got %0d low cycles want 0", lo); end
        total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL relb_level_off: got %b want 0", btn_level); end
        wait_cyc(r + 3);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (obs_q.size() == 0) begin
                bad++; ex = exp_q.pop_front();
                $display("FAIL relb_event: got none want kind=%0d cyc=%0d", ex.kind, ex.cyc);
            end else if (exp_q.size() == 0) begin
                bad++; ob = obs_q.pop_front();
                $display("FAIL relb_event: got kind=%0d cyc=%0d want none", ob.kind, ob.cyc);
            end else begin
                ex = exp_q.pop_front(); ob = obs_q.pop_front();
                if (ob !== ex) begin
                    bad++;
                    $display("FAIL relb_event: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", ob.kind, ob.cyc, ex.kind, ex.cyc);
                end
            end
        end
    endtask

    task automatic test_long_press;
        int e, r;
        ev_t ex, ob;
        press(e);
        exp_q.push_back(mk(EV_LONG, nth_tick(e, LONG)));
        wait_cyc(e + 200);
        release_btn(r);
        wait_cyc(r + 3);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (obs_q.size() == 0) begin
                bad++; ex = exp_q.pop_front();
                $display("FAIL long_event: got none want kind=%0d cyc=%0d", ex.kind, ex.cyc);
            end else if (exp_q.size() == 0) begin
                bad++; ob = obs_q.pop_front();
                $display("FAIL long_event: got kind=%0d cyc=%0d want none", ob.kind, ob.cyc);
            end else begin
                ex = exp_q.pop_front(); ob = obs_q.pop_front();
                if (ob !== ex) begin
                    bad++;
                    $display("FAIL long_event: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", ob.kind, ob.cyc, ex.kind, ex.cyc);
                end
            end
        end
    endtask

    task automatic test_collision;
        int e, r;
        ev_t ex, ob;
        // Synchronised edge reaches the FSM on a tick edge
        while ((cyc + 3) % TICK_PER != 0) @(negedge clk_100Mhz);
        press(e);
        wait_cyc(e - TICK_PER);
        total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL collide_level_3tick: got %b want 0", btn_level); end
        wait_cyc(e);
        total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL collide_level_4tick: got %b want 1", btn_level); end
        wait_cyc(e + 10);
        release_btn(r);
        wait_cyc(r + 3);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (obs_q.size() == 0) begin
                bad++; ex = exp_q.pop_front();
                $display("FAIL collide_event: got none want kind=%0d cyc=%0d", ex.kind, ex.cyc);
            end else if (exp_q.size() == 0) begin
                bad++; ob = obs_q.pop_front();
                $display("FAIL collide_event: got kind=%0d cyc=%0d want none", ob.kind, ob.cyc);
            end else begin
                ex = exp_q.pop_front(); ob = obs_q.pop_front();
                if (ob !== ex) begin
                    bad++;
                    $display("FAIL collide_event: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", ob.kind, ob.cyc, ex.kind, ex.cyc);
                end
            end
        end
    endtask

    task automatic test_reset_midop;
        int t2, e2, e3, r2, r;
        ev_t ex, ob;
        btn_in = 1'b1;
        t2 = nth_tick(cyc + 3, 2);
        // dcnt is 2 after tick t2; reset lands two clocks before the next tick
        wait_cyc(t2 + 7);
        rst_n = 1'b0;
        wait_cyc(t2 + 8);
        total++; if (btn_level !== 1'b0)    begin bad++; $display("FAIL rstpw_level: got %b want 0", btn_level); end
        total++; if (btn_pressed !== 1'b0)  begin bad++; $display("FAIL rstpw_pressed: got %b want 0", btn_pressed); end
        rst_n = 1'b1;
        e2 = nth_tick(cyc + 3, DEB);
        exp_q.push_back(mk(EV_PRESS, e2));
        wait_cyc(e2 + 15);
        rst_n = 1'b0;
        wait_cyc(e2 + 16);
        total++; if (btn_level !== 1'b0)    begin bad++; $display("FAIL rstpr_level: got %b want 0", btn_level); end
        total++; if (btn_released !== 1'b0) begin bad++; $display("FAIL rstpr_released: got %b want 0", btn_released); end
        rst_n = 1'b1;
        r2 = cyc;
        e3 = nth_tick(r2 + 3, DEB);
        exp_q.push_back(mk(EV_PRESS, e3));
        wait_cyc(e3);
        total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL rstpr_relevel: got %b want 1", btn_level); end
        wait_cyc(e3 + 10);
        release_btn(r);
        wait_cyc(r + 3);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (obs_q.size() == 0) begin
                bad++; ex = exp_q.pop_front();
                $display("FAIL rstmid_event: got none want kind=%0d cyc=%0d", ex.kind, ex.cyc);
            end else if (exp_q.size() == 0) begin
                bad++; ob = obs_q.pop_front();
                $display("FAIL rstmid_event: got kind=%0d cyc=%0d want none", ob.kind, ob.cyc);
            end else begin
                ex = exp_q.pop_front(); ob = obs_q.pop_front();
                if (ob !== ex) begin
                    bad++;
                    $display("FAIL rstmid_event: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", ob.kind, ob.cyc, ex.kind, ex.cyc);
                end
            end
        end
    endtask

    task automatic test_exclusive;
        total++;
        if (multi !== 0) begin bad++; $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", multi); end
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_long_press();
        test_collision();
        test_reset_midop();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
